// File: rtl/def.sv
// rtl/def.sv - shared CPU definitions: opcode constants and display sampler types
package def;

  // Opcode encoding as retired by the CPU
  localparam logic [7:0] NOP  = 8'h00;
  localparam logic [7:0] LDI  = 8'hE0;
  localparam logic [7:0] ORI  = 8'h60;
  localparam logic [7:0] ADDI = 8'h70;
  localparam logic [7:0] SUBI = 8'h50;
  localparam logic [7:0] INC  = 8'h93;
  localparam logic [7:0] CLR  = 8'h24;

  typedef enum logic [1:0] {IDLE, SHOW, READY, FROZEN} sampler_state_t;

  // 0.5 s at 50 MHz
  localparam int DISPLAY_HOLD_CYCLES = 25_000_000;

endpackage

// File: rtl/key_edge_sync.sv
// rtl/key_edge_sync.sv - two-stage key synchroniser with falling-edge press pulse
//
// Ports:
//   clock      in  system clock
//   reset_s2_n in  async active-low reset; all flops reset to 1 (key released)
//   key_n      in  raw active-low key, asynchronous to clock
//   pressed    out one-cycle pulse per key press
module key_edge_sync (
  input  logic clock,
  input  logic reset_s2_n,
  input  logic key_n,
  output logic pressed
);

  logic sync1;
  logic sync2;
  logic last;

  always_ff @(posedge clock or negedge reset_s2_n) begin
    if (!reset_s2_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      last  <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      last  <= sync2;
    end
  end

  // High while the synchronised key has just gone from released to pressed
  assign pressed = last & ~sync2;

endmodule

// File: rtl/display_sampler.sv
// rtl/display_sampler.sv - holds retired opcode/R16 pairs long enough to read, with freeze
//
// Ports:
//   clock, reset_s2_n            clock and async active-low reset
//   cpu_op_code, cpu_r16         retiring instruction's opcode and R16, valid with instr_done
//   instr_done                   one-cycle retire strobe
//   freeze_key_n                 raw freeze push-button, active-low
//   display_on                   0 blanks the display without stopping capture
//   enable, op_code, r16         to the 7-segment driver
//   frozen                       freeze-mode LED
//   skip_count                   saturating count of strobes not captured
module display_sampler
  import def::*;
#(
  parameter int HOLD_CYCLES = DISPLAY_HOLD_CYCLES,
  parameter int SKIP_W      = 8
) (
  input  logic              clock,
  input  logic              reset_s2_n,
  input  logic [7:0]        cpu_op_code,
  input  logic [7:0]        cpu_r16,
  input  logic              instr_done,
  input  logic              freeze_key_n,
  input  logic              display_on,
  output logic              enable,
  output logic [7:0]        op_code,
  output logic [7:0]        r16,
  output logic              frozen,
  output logic [SKIP_W-1:0] skip_count
);

  localparam int CW = $clog2(HOLD_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

  sampler_state_t state;
  sampler_state_t next_state;
  logic [CW-1:0]  hold_cnt;
  logic           pressed;
  logic           capture;
  logic           skip;

  key_edge_sync u_key (
    .clock      (clock),
    .reset_s2_n (reset_s2_n),
    .key_n      (freeze_key_n),
    .pressed    (pressed)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:   if (instr_done) next_state = SHOW;
      SHOW: begin
        if (pressed)                         next_state = FROZEN;
        else if (hold_cnt == '0 && !instr_done) next_state = READY;
      end
      READY: begin
        if (pressed)         next_state = FROZEN;
        else if (instr_done) next_state = SHOW;
      end
      FROZEN: if (pressed) next_state = READY;
      default: next_state = IDLE;
    endcase
  end

  // A press takes priority over a simultaneous strobe; every strobe that is
  // not captured counts as skipped.
  always_comb begin
    capture = 1'b0;
    case (state)
      IDLE:    capture = instr_done;
      SHOW:    capture = instr_done && !pressed && (hold_cnt == '0);
      READY:   capture = instr_done && !pressed;
      default: capture = 1'b0;
    endcase
    skip = instr_done && !capture;
  end

  always_ff @(posedge clock or negedge reset_s2_n) begin
    if (!reset_s2_n) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      op_code    <= NOP;
      r16        <= 8'h00;
      enable     <= 1'b0;
      frozen     <= 1'b0;
      skip_count <= '0;
    end else begin
      state <= next_state;
      if (capture) begin
        op_code  <= cpu_op_code;
        r16      <= cpu_r16;
        hold_cnt <= RELOAD;
      end else if (next_state == SHOW) begin
        // Staying in SHOW without a capture implies hold_cnt is non-zero
        hold_cnt <= hold_cnt - CW'(1);
      end else begin
        hold_cnt <= '0;
      end
      if (skip && skip_count != '1) begin
        skip_count <= skip_count + SKIP_W'(1);
      end
      enable <= (next_state != IDLE) && display_on;
      frozen <= (next_state == FROZEN);
    end
  end

endmodule

// File: tb/tb_display_sampler.sv
// tb/tb_display_sampler.sv - self-checking bench for display_sampler
module tb_display_sampler;
  import def::*;

  localparam int HOLD = 4;
  localparam int M_IDLE = 0, M_SHOW = 1, M_READY = 2, M_FROZEN = 3;

  logic       clock = 1'b0;
  logic       reset_s2_n = 1'b0;
  logic [7:0] cpu_op_code = 8'h00;
  logic [7:0] cpu_r16 = 8'h00;
  logic       instr_done = 1'b0;
  logic       freeze_key_n = 1'b1;
  logic       display_on = 1'b1;
  logic       enable;
  logic [7:0] op_code;
  logic [7:0] r16;
  logic       frozen;
  logic [7:0] skip_count;

  display_sampler #(.HOLD_CYCLES(HOLD), .SKIP_W(8)) dut (
    .clock        (clock),
    .reset_s2_n   (reset_s2_n),
    .cpu_op_code  (cpu_op_code),
    .cpu_r16      (cpu_r16),
    .instr_done   (instr_done),
    .freeze_key_n (freeze_key_n),
    .display_on   (display_on),
    .enable       (enable),
    .op_code      (op_code),
    .r16          (r16),
    .frozen       (frozen),
    .skip_count   (skip_count)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_mode, m_skip, edge_n, cap_edge;
  logic [7:0] m_op, m_r;
  logic       m_en, m_frz;
  logic [2:0] kh;          // key level at the last three edges, [0] newest
  logic       key = 1'b1;
  logic       don = 1'b1;

  task automatic model_reset();
    m_mode = M_IDLE; m_skip = 0; edge_n = 0; cap_edge = 0;
    m_op = NOP; m_r = 8'h00; m_en = 1'b0; m_frz = 1'b0; kh = 3'b111;
  endtask

  task automatic model_step(input logic d, input logic [7:0] op, input logic [7:0] r,
                            input logic k, input logic dn);
    logic press;
    logic take;
    press = kh[2] & ~kh[1];  // key fell three edges ago
    kh = {kh[1:0], k};
    edge_n++;
    take = 1'b0;
    if (m_mode == M_IDLE) begin
      take = d;
    end else if (m_mode == M_FROZEN) begin
      if (d && m_skip < 255) m_skip++;
      if (press) m_mode = M_READY;
    end else if (press) begin
      m_mode = M_FROZEN;
      if (d && m_skip < 255) m_skip++;
    end else if (d) begin
      if (m_mode == M_READY || edge_n - cap_edge >= HOLD) take = 1'b1;
      else if (m_skip < 255) m_skip++;
    end else if (m_mode == M_SHOW && edge_n - cap_edge >= HOLD) begin
      m_mode = M_READY;
    end
    if (take) begin
      m_op = op; m_r = r; m_mode = M_SHOW; cap_edge = edge_n;
    end
    m_en  = (m_mode != M_IDLE) && dn;
    m_frz = (m_mode == M_FROZEN);
  endtask

  // Drives one clock cycle of stimulus; returns at the following negedge.
  task automatic tick(input logic d, input logic [7:0] op, input logic [7:0] r);
    instr_done = d; cpu_op_code = op; cpu_r16 = r;
    freeze_key_n = key; display_on = don;
    @(posedge clock);
    model_step(d, op, r, key, don);
    @(negedge clock);
    instr_done = 1'b0;
  endtask

  function automatic logic [25:0] expv();
    return {m_en, m_frz, m_op, m_r, 8'(m_skip)};
  endfunction

  task automatic test_reset();
    reset_s2_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({enable, frozen, op_code, r16, skip_count} !== {1'b0, 1'b0, NOP, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL reset_values got %h want %h", {enable, frozen, op_code, r16, skip_count},
               {1'b0, 1'b0, NOP, 8'h00, 8'h00});
    end
    @(negedge clock); @(negedge clock);
    reset_s2_n = 1'b1;
    tick(1'b0, 8'h00, 8'h00);
    checks++;
    if (enable !== 1'b0 || op_code !== NOP) begin
      errors++;
      $display("FAIL idle_after_reset got en=%b op=%h want en=0 op=%h", enable, op_code, NOP);
    end
  endtask

  task automatic test_hold();
    tick(1'b1, LDI, 8'h02);
    checks++;
    if ({enable, op_code, r16} !== {1'b1, LDI, 8'h02}) begin
      errors++;
      $display("FAIL first_capture got en=%b op=%h r=%h want 1 %h 02", enable, op_code, r16, LDI);
    end
    for (int i = 0; i < 6; i++) begin
      tick(1'b0, 8'hFF, 8'hFF);
      checks++;
      if ({enable, frozen, op_code, r16, skip_count} !== expv()) begin
        errors++;
        $display("FAIL hold_cycle%0d got %h want %h", i, {enable, frozen, op_code, r16, skip_count}, expv());
      end
    end
  endtask

  task automatic test_skip();
    int s0;
    s0 = m_skip;
    tick(1'b1, ORI, 8'h20);
    tick(1'b1, ADDI, 8'h21);
    tick(1'b1, SUBI, 8'h22);
    checks++;
    if ({op_code, r16, skip_count} !== {ORI, 8'h20, 8'(s0 + 2)}) begin
      errors++;
      $display("FAIL skip_during_hold got op=%h r=%h skip=%0d want %h 20 %0d", op_code, r16, skip_count, ORI, s0 + 2);
    end
    tick(1'b0, 8'h00, 8'h00);
    tick(1'b0, 8'h00, 8'h00);
    tick(1'b1, ADDI, 8'h33);
    checks++;
    if ({op_code, r16, skip_count} !== {ADDI, 8'h33, 8'(s0 + 2)}) begin
      errors++;
      $display("FAIL capture_after_expiry got op=%h r=%h skip=%0d want %h 33 %0d", op_code, r16, skip_count, ADDI, s0 + 2);
    end
  endtask

  task automatic test_boundary();
    int s0;
    s0 = m_skip;
    for (int i = 0; i < HOLD - 1; i++) tick(1'b0, 8'h00, 8'h00);
    tick(1'b1, INC, 8'h05);
    checks++;
    if ({enable, op_code, r16, skip_count} !== {1'b1, INC, 8'h05, 8'(s0)}) begin
      errors++;
      $display("FAIL strobe_at_zero got en=%b op=%h r=%h skip=%0d want 1 %h 05 %0d", enable, op_code, r16, skip_count, INC, s0);
    end
    // Counter was reloaded, so the very next strobe must be skipped
    tick(1'b1, CLR, 8'h77);
    checks++;
    if ({op_code, skip_count} !== {INC, 8'(s0 + 1)}) begin
      errors++;
      $display("FAIL reload_after_zero got op=%h skip=%0d want %h %0d", op_code, skip_count, INC, s0 + 1);
    end
  endtask

  task automatic press_key();
    key = 1'b0;
    for (int i = 0; i < 3; i++) tick(1'b0, 8'h00, 8'h00);
    key = 1'b1;
  endtask

  task automatic test_freeze();
    int s0;
    logic [7:0] op0;
    press_key();
    checks++;
    if (frozen !== 1'b1) begin
      errors++;
      $display("FAIL freeze_enter got frozen=%b want 1", frozen);
    end
    op0 = m_op;
    s0 = m_skip;
    for (int i = 0; i < 3; i++) tick(1'b1, 8'(i + 8'hA0), 8'(i));
    checks++;
    if ({frozen, op_code, skip_count} !== {1'b1, op0, 8'(s0 + 3)}) begin
      errors++;
      $display("FAIL frozen_skips got f=%b op=%h skip=%0d want 1 %h %0d", frozen, op_code, skip_count, op0, s0 + 3);
    end
    tick(1'b0, 8'h00, 8'h00);
    press_key();
    checks++;
    if (frozen !== 1'b0) begin
      errors++;
      $display("FAIL freeze_exit got frozen=%b want 0", frozen);
    end
    tick(1'b1, CLR, 8'h00);
    checks++;
    if ({enable, op_code, r16} !== {1'b1, CLR, 8'h00}) begin
      errors++;
      $display("FAIL ready_capture got en=%b op=%h r=%h want 1 %h 00", enable, op_code, r16, CLR);
    end
  endtask

  task automatic test_press_and_strobe();
    int s0;
    s0 = m_skip;
    for (int i = 0; i < HOLD; i++) tick(1'b0, 8'h00, 8'h00);
    key = 1'b0;
    tick(1'b0, 8'h00, 8'h00);
    tick(1'b0, 8'h00, 8'h00);
    tick(1'b1, LDI, 8'hEE);
    key = 1'b1;
    checks++;
    if ({frozen, op_code, r16, skip_count} !== {1'b1, CLR, 8'h00, 8'(s0 + 1)}) begin
      errors++;
      $display("FAIL press_beats_strobe got f=%b op=%h r=%h skip=%0d want 1 %h 00 %0d", frozen, op_code, r16, skip_count, CLR, s0 + 1);
    end
    tick(1'b0, 8'h00, 8'h00);
    press_key();
  endtask

  task automatic test_display_and_reset();
    don = 1'b0;
    tick(1'b1, ORI, 8'h41);
    checks++;
    if ({enable, op_code, r16} !== {1'b0, ORI, 8'h41}) begin
      errors++;
      $display("FAIL blank_capture got en=%b op=%h r=%h want 0 %h 41", enable, op_code, r16, ORI);
    end
    for (int i = 0; i < HOLD; i++) tick(1'b0, 8'h00, 8'h00);
    tick(1'b1, SUBI, 8'h42);
    don = 1'b1;
    tick(1'b0, 8'h00, 8'h00);
    checks++;
    if ({enable, op_code, r16} !== {1'b1, SUBI, 8'h42}) begin
      errors++;
      $display("FAIL reenable got en=%b op=%h r=%h want 1 %h 42", enable, op_code, r16, SUBI);
    end
    #2 reset_s2_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({enable, frozen, op_code, r16, skip_count} !== {1'b0, 1'b0, NOP, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL async_reset got %h want %h", {enable, frozen, op_code, r16, skip_count},
               {1'b0, 1'b0, NOP, 8'h00, 8'h00});
    end
    @(negedge clock);
    reset_s2_n = 1'b1;
    press_key();
    checks++;
    if ({enable, frozen} !== 2'b00) begin
      errors++;
      $display("FAIL idle_ignores_press got en=%b f=%b want 0 0", enable, frozen);
    end
  endtask

  task automatic test_saturation();
    tick(1'b1, LDI, 8'h01);
    press_key();
    for (int i = 0; i < 260; i++) tick(1'b1, 8'(i), 8'(i));
    checks++;
    if ({frozen, skip_count} !== {1'b1, 8'd255}) begin
      errors++;
      $display("FAIL skip_saturate got f=%b skip=%0d want 1 255", frozen, skip_count);
    end
    press_key();
  endtask

  task automatic test_random();
    reset_s2_n = 1'b0;
    key = 1'b1;
    don = 1'b1;
    model_reset();
    @(negedge clock);
    reset_s2_n = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) key = ~key;
      if ($urandom_range(0, 15) == 0) don = ~don;
      tick($urandom_range(0, 2) == 0, 8'($urandom), 8'($urandom));
      checks++;
      if ({enable, frozen, op_code, r16, skip_count} !== expv()) begin
        errors++;
        $display("FAIL random_cycle%0d got %h want %h", i, {enable, frozen, op_code, r16, skip_count}, expv());
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_skip();
    test_boundary();
    test_freeze();
    test_press_and_strobe();
    test_display_and_reset();
    test_saturation();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
